// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and dctag field positions for the L1 data cache.
package dcache_pkg;
  localparam int DC_IDXW  = 9;
  localparam int DC_BEATS = 2;
  localparam int DC_TAGW  = 20;

  // dctag = {valid, dirty, tag}
  localparam int DCTAG_V = DC_TAGW + 1;
  localparam int DCTAG_D = DC_TAGW;

  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_WB   = 2'd1,
    DC_FILL = 2'd2,
    DC_DONE = 2'd3
  } dc_state_e;
endpackage

// File: rtl/dcache_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module dcache_ram #(
  parameter  int AW     = 10,
  parameter  int DATA_W = 64,
  localparam int BE_W   = (DATA_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];

  // Bit-granular mask lets a width that is not a byte multiple share the same lane scheme.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (be[i/8]) mem[addr][i] <= wdata[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back VIPT L1 data cache with line fill/write-back FSM.
// Optional DCACHE_STATS_EN adds hit/miss/write-back counters.
module dcache
  import dcache_pkg::*;
#(
  parameter int IDXW  = DC_IDXW,
  parameter int BEATS = DC_BEATS,
  parameter int TAGW  = DC_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phi1,
  input  logic            phi2,
  input  logic [63:0]     dcva,
  input  logic [63:0]     dcwdata,
  input  logic [2:0]      dcsz,
  input  logic            dcread,
  input  logic            dcwrite,
  input  logic            dcfill,
  input  logic [TAGW-1:0] jtlbpa,
  output logic [63:0]     dcdata,
  output logic [TAGW+1:0] dctag,
  output logic            dcbusy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [63:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [63:0]     mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]     st_hit,
  output logic [31:0]     st_miss,
  output logic [31:0]     st_wb
`endif
);
  localparam int OFFW  = $clog2(8 * BEATS);
  localparam int BW    = $clog2(BEATS);
  localparam int PGW   = 32 - TAGW;
  localparam int LINES = 1 << IDXW;

  function automatic int shift_bytes(input logic [2:0] o, input logic [2:0] sz);
    int sh;
    sh = 7 - int'(o) - int'(sz);
    if (sh < 0) sh = 0;
    return sh;
  endfunction

  function automatic logic [63:0] size_mask(input logic [2:0] sz);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) if (k <= int'(sz)) m[8*k +: 8] = 8'hff;
    return m;
  endfunction

  // Big-endian dword: byte at offset k lives in lane 7-k.
  function automatic logic [63:0] ld_align(input logic [63:0] dw, input logic [2:0] o,
                                           input logic [2:0] sz);
    return (dw >> (8 * shift_bytes(o, sz))) & size_mask(sz);
  endfunction

  function automatic logic [63:0] st_align(input logic [63:0] wd, input logic [2:0] o,
                                           input logic [2:0] sz);
    return (wd & size_mask(sz)) << (8 * shift_bytes(o, sz));
  endfunction

  function automatic logic [7:0] be_mask(input logic [2:0] o, input logic [2:0] sz);
    logic [7:0] be;
    be = '0;
    for (int k = 0; k < 8; k++) be[7-k] = (k >= int'(o)) && (k <= int'(o) + int'(sz));
    return be;
  endfunction

  dc_state_e state, nstate;
  logic [BW-1:0]     beat, beat_nx;
  logic              gap;
  logic [IDXW-1:0]   f_idx;
  logic [TAGW-1:0]   f_pa;
  logic [LINES-1:0]  valid, dirty;
  logic              line_vld_p1, line_dty_p1;
  logic [2:0]        off_p1, sz_p1;
  logic [63:0]       dword_hold;
  logic [TAGW-1:0]   tag_hold;

  logic [IDXW-1:0]   idx;
  logic [BW-1:0]     dw;
  logic [2:0]        off;
  logic              idle, start, victim_dirty, user_rd, hit, st_do, beat_ack, last;
  logic [PGW-1:0]    la;

  logic              d_re, d_we, t_re, t_we;
  logic [IDXW+BW-1:0] d_addr;
  logic [IDXW-1:0]   t_addr;
  logic [7:0]        d_be;
  logic [63:0]       d_wdata, d_rdata;
  logic [TAGW-1:0]   t_rdata;
  logic              unused_va;

  assign idx          = dcva[IDXW+OFFW-1:OFFW];
  assign dw           = dcva[OFFW-1:3];
  assign off          = dcva[2:0];
  assign unused_va    = ^dcva[63:IDXW+OFFW];
  assign idle         = (state == DC_IDLE);
  assign start        = idle && dcfill;
  assign victim_dirty = valid[idx] && dirty[idx];
  assign user_rd      = idle && phi1 && !dcfill && (dcread || dcwrite);
  assign hit          = line_vld_p1 && (t_rdata == jtlbpa);
  assign st_do        = idle && phi2 && !dcfill && dcwrite && hit;
  assign mem_req      = ((state == DC_WB) || (state == DC_FILL)) && !gap;
  assign beat_ack     = mem_req && mem_ack;
  assign last         = (beat == BW'(BEATS - 1));
  assign beat_nx      = beat + BW'(1);
  assign la           = PGW'({f_idx, beat, 3'b000});

  assign dcbusy    = !idle;
  assign mem_we    = (state == DC_WB);
  assign mem_wdata = (state == DC_WB) ? d_rdata : '0;
  assign mem_addr  = (state == DC_WB)   ? {t_rdata, la} :
                     (state == DC_FILL) ? {f_pa, la}    : '0;
  assign dcdata    = ld_align(idle ? d_rdata : dword_hold, off_p1, sz_p1);
  assign dctag     = {line_vld_p1, line_dty_p1, idle ? t_rdata : tag_hold};

  always_comb begin
    nstate = state;
    case (state)
      DC_IDLE: if (dcfill) nstate = victim_dirty ? DC_WB : DC_FILL;
      DC_WB:   if (beat_ack && last) nstate = DC_FILL;
      DC_FILL: if (beat_ack && last) nstate = DC_DONE;
      DC_DONE: nstate = DC_IDLE;
    endcase
  end

  // Single RAM port arbitration: fill traffic owns it while busy, the CPU otherwise.
  always_comb begin
    d_re    = 1'b0;
    d_we    = 1'b0;
    d_addr  = {idx, dw};
    d_be    = '0;
    d_wdata = st_align(dcwdata, off, dcsz);
    t_re    = 1'b0;
    t_we    = 1'b0;
    t_addr  = idx;
    case (state)
      DC_IDLE: begin
        if (start) begin
          if (victim_dirty) begin
            d_re   = 1'b1;
            d_addr = {idx, {BW{1'b0}}};
            t_re   = 1'b1;
          end
        end else if (user_rd) begin
          d_re = 1'b1;
          t_re = 1'b1;
        end else if (st_do) begin
          d_we = 1'b1;
          d_be = be_mask(off, dcsz);
        end
      end
      DC_WB: begin
        d_addr = {f_idx, beat_nx};
        d_re   = beat_ack && !last;
      end
      DC_FILL: begin
        d_addr  = {f_idx, beat};
        d_wdata = mem_rdata;
        d_be    = '1;
        d_we    = beat_ack;
        t_addr  = f_idx;
        t_we    = beat_ack && last;
      end
      DC_DONE: begin
        d_re = 1'b1;
        t_re = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DC_IDLE;
      beat        <= '0;
      gap         <= 1'b0;
      valid       <= '0;
      dirty       <= '0;
      line_vld_p1 <= 1'b0;
      line_dty_p1 <= 1'b0;
      off_p1      <= '0;
      sz_p1       <= '0;
    end else begin
      state <= nstate;
      case (state)
        DC_IDLE: begin
          if (start) begin
            beat         <= '0;
            gap          <= 1'b0;
            valid[idx]   <= 1'b0;
            dirty[idx]   <= 1'b0;
          end else if (user_rd) begin
            line_vld_p1 <= valid[idx];
            line_dty_p1 <= dirty[idx];
            off_p1      <= off;
            sz_p1       <= dcsz;
          end else if (st_do) begin
            dirty[idx] <= 1'b1;
          end
        end
        DC_WB: begin
          if (beat_ack) begin
            if (last) begin
              beat <= '0;
              gap  <= 1'b1;
            end else begin
              beat <= beat_nx;
            end
          end
        end
        DC_FILL: begin
          if (gap) begin
            gap <= 1'b0;
          end else if (beat_ack) begin
            if (last) begin
              beat         <= '0;
              valid[f_idx] <= 1'b1;
              dirty[f_idx] <= 1'b0;
            end else begin
              beat <= beat_nx;
            end
          end
        end
        DC_DONE: begin
          line_vld_p1 <= valid[idx];
          line_dty_p1 <= dirty[idx];
          off_p1      <= off;
          sz_p1       <= dcsz;
        end
      endcase
    end
  end

  // Fill context and the output hold copy are pure data: no reset needed.
  always_ff @(posedge clk) begin
    if (start) begin
      f_idx <= idx;
      f_pa  <= jtlbpa;
    end
    if (idle) begin
      dword_hold <= d_rdata;
      tag_hold   <= t_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_hit  <= '0;
      st_miss <= '0;
      st_wb   <= '0;
    end else begin
      if (idle && phi2 && !dcfill && (dcread || dcwrite) && hit) st_hit <= st_hit + 32'd1;
      if (start) st_miss <= st_miss + 32'd1;
      if (start && victim_dirty) st_wb <= st_wb + 32'd1;
    end
  end
`endif

  dcache_ram #(.AW(IDXW + BW), .DATA_W(64)) u_data (
    .clk   (clk),
    .rst   (rst),
    .re    (d_re),
    .we    (d_we),
    .addr  (d_addr),
    .be    (d_be),
    .wdata (d_wdata),
    .rdata (d_rdata)
  );

  dcache_ram #(.AW(IDXW), .DATA_W(TAGW)) u_tag (
    .clk   (clk),
    .rst   (rst),
    .re    (t_re),
    .we    (t_we),
    .addr  (t_addr),
    .be    ('1),
    .wdata (f_pa),
    .rdata (t_rdata)
  );
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: table-driven loads plus fill, write-back and reset sequences.
module tb_dcache;
  logic        clk = 1'b0;
  logic        rst, phi1, phi2;
  logic [63:0] dcva, dcwdata;
  logic [2:0]  dcsz;
  logic        dcread, dcwrite, dcfill;
  logic [19:0] jtlbpa;
  logic [63:0] dcdata;
  logic [21:0] dctag;
  logic        dcbusy, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  dcache dut (
    .clk(clk), .rst(rst), .phi1(phi1), .phi2(phi2),
    .dcva(dcva), .dcwdata(dcwdata), .dcsz(dcsz), .dcread(dcread), .dcwrite(dcwrite),
    .dcfill(dcfill), .jtlbpa(jtlbpa), .dcdata(dcdata), .dctag(dctag), .dcbusy(dcbusy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    logic [63:0] va;
    logic [2:0]  sz;
    logic [19:0] pa;
    logic [63:0] exp_d;
    logic [21:0] exp_t;
  } vec_t;

  beat_t       log_q[$];
  logic [63:0] mem_model [logic [31:0]];
  int          acks_left = 1000000;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [63:0] mdata(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, ~a};
  endfunction

  function automatic beat_t get_beat(input int i);
    beat_t b;
    b = '{we: 1'b1, addr: 32'hFFFF_FFFF, wdata: 64'h0};
    if (i < log_q.size()) b = log_q[i];
    return b;
  endfunction

  // Memory responder: one ack per beat, with a budget used to stall mid-line.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !mem_ack && acks_left > 0) begin
        log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        mem_rdata = mdata(mem_addr);
        mem_ack   = 1'b1;
        acks_left--;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    phi1 = ~phi1;
    phi2 = ~phi2;
  endtask

  task automatic load(input logic [63:0] va, input logic [2:0] sz, input logic [19:0] pa,
                      output logic [63:0] d, output logic [21:0] t);
    if (!phi1) cyc();
    dcva = va; dcsz = sz; jtlbpa = pa; dcread = 1'b1;
    cyc();
    d = dcdata;
    t = dctag;
    cyc();
    dcread = 1'b0;
  endtask

  task automatic store(input logic [63:0] va, input logic [2:0] sz, input logic [63:0] wd,
                       input logic [19:0] pa);
    if (!phi1) cyc();
    dcva = va; dcsz = sz; dcwdata = wd; jtlbpa = pa; dcwrite = 1'b1;
    cyc();
    cyc();
    dcwrite = 1'b0;
  endtask

  // dcfill is dropped as soon as the FSM goes busy: the line must still complete.
  task automatic fill(input logic [63:0] va, input logic [19:0] pa);
    bit seen;
    bit done;
    log_q.delete();
    dcva = va; jtlbpa = pa; dcfill = 1'b1;
    seen = 0;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      cyc();
      if (dcbusy) begin
        seen   = 1;
        dcfill = 1'b0;
      end else if (seen) begin
        done = 1;
      end
    end
    dcfill = 1'b0;
    chk("fill_done", {63'b0, done}, 64'd1);
  endtask

  vec_t        tbl[7];
  logic [63:0] d;
  logic [21:0] t;
  beat_t       b;
  bit          found;

  initial begin
    rst = 1'b1; phi1 = 1'b1; phi2 = 1'b0;
    dcva = '0; dcwdata = '0; dcsz = '0; dcread = 1'b0; dcwrite = 1'b0; dcfill = 1'b0;
    jtlbpa = '0;

    tbl[0] = '{64'h101, 3'd0, 20'h00012, 64'h11,                  22'h200012};
    tbl[1] = '{64'h10A, 3'd1, 20'h00012, 64'hAABB,                22'h200012};
    tbl[2] = '{64'h108, 3'd7, 20'h00012, 64'h8899AABBCCDDEEFF,    22'h200012};
    tbl[3] = '{64'h100, 3'd7, 20'h00012, 64'h0011223344556677,    22'h200012};
    tbl[4] = '{64'h104, 3'd3, 20'h00012, 64'h44556677,            22'h200012};
    tbl[5] = '{64'h10F, 3'd0, 20'h00012, 64'hFF,                  22'h200012};
    tbl[6] = '{64'h105, 3'd2, 20'h00012, 64'h556677,              22'h200012};

    mem_model[32'h00012100] = 64'h0011223344556677;
    mem_model[32'h00012108] = 64'h8899AABBCCDDEEFF;
    mem_model[32'h00034100] = 64'hA5A50000_11112222;
    mem_model[32'h00034108] = 64'h33334444_55556666;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dcdata",    dcdata,    64'h0);
    chk("rst_dctag",     dctag,     64'h0);
    chk("rst_dcbusy",    dcbusy,    64'h0);
    chk("rst_mem_req",   mem_req,   64'h0);
    chk("rst_mem_addr",  mem_addr,  64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    rst = 1'b0;

    // Cold refill of a clean line
    fill(64'h100, 20'h00012);
    chk("f1_nbeats", log_q.size(), 64'd2);
    b = get_beat(0);
    chk("f1_b0_addr", b.addr, 64'h00012100);
    chk("f1_b0_we",   b.we,   64'h0);
    b = get_beat(1);
    chk("f1_b1_addr", b.addr, 64'h00012108);
    chk("f1_b1_we",   b.we,   64'h0);
    chk("f1_dctag",   dctag,  64'h200012);

    for (int i = 0; i < 7; i++) begin
      load(tbl[i].va, tbl[i].sz, tbl[i].pa, d, t);
      chk($sformatf("ld%0d_data", i), d, tbl[i].exp_d);
      chk($sformatf("ld%0d_tag", i),  t, tbl[i].exp_t);
    end

    // Stores: hit merges bytes and sets dirty; a tag miss is dropped
    store(64'h102, 3'd1, 64'hBEEF, 20'h00012);
    load(64'h100, 3'd7, 20'h00012, d, t);
    chk("st_hit_data", d, 64'h0011BEEF44556677);
    chk("st_hit_tag",  t, 64'h300012);
    store(64'h100, 3'd7, 64'hFFFFFFFF_FFFFFFFF, 20'h00099);
    load(64'h100, 3'd7, 20'h00012, d, t);
    chk("st_miss_data", d, 64'h0011BEEF44556677);
    store(64'h10F, 3'd0, 64'h5A, 20'h00012);
    load(64'h108, 3'd7, 20'h00012, d, t);
    chk("st_b7_data", d, 64'h8899AABBCCDDEE5A);

    // Dirty victim: write-back of both beats, then refill from the new page
    fill(64'h100, 20'h00034);
    chk("f2_nbeats", log_q.size(), 64'd4);
    b = get_beat(0);
    chk("wb0_addr",  b.addr,  64'h00012100);
    chk("wb0_we",    b.we,    64'h1);
    chk("wb0_wdata", b.wdata, 64'h0011BEEF44556677);
    b = get_beat(1);
    chk("wb1_addr",  b.addr,  64'h00012108);
    chk("wb1_wdata", b.wdata, 64'h8899AABBCCDDEE5A);
    b = get_beat(2);
    chk("rf0_addr",  b.addr,  64'h00034100);
    chk("rf0_we",    b.we,    64'h0);
    b = get_beat(3);
    chk("rf1_addr",  b.addr,  64'h00034108);
    chk("f2_dctag",  dctag,   64'h200034);
    load(64'h108, 3'd7, 20'h00034, d, t);
    chk("f2_data", d, 64'h33334444_55556666);

    // Reset while the second refill beat is outstanding
    log_q.delete();
    acks_left = 1;
    dcva = 64'h200; jtlbpa = 20'h00056; dcfill = 1'b1;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      cyc();
      if (dcbusy) dcfill = 1'b0;
      if (mem_req && mem_addr == 32'h00056208) found = 1;
    end
    dcfill = 1'b0;
    chk("rst_wait", {63'b0, found}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req",  mem_req,  64'h0);
    chk("mid_rst_busy", dcbusy,   64'h0);
    chk("mid_rst_tag",  dctag,    64'h0);
    chk("mid_rst_addr", mem_addr, 64'h0);
    cyc();
    rst = 1'b0;
    acks_left = 1000000;
    load(64'h200, 3'd7, 20'h00056, d, t);
    chk("rst_inval_200", t[21], 64'h0);
    load(64'h100, 3'd7, 20'h00034, d, t);
    chk("rst_inval_100", t[21], 64'h0);

    fill(64'h200, 20'h00056);
    chk("f3_nbeats", log_q.size(), 64'd2);
    b = get_beat(0);
    chk("f3_b0_addr", b.addr, 64'h00056200);
    chk("f3_dctag",   dctag,  64'h200056);
    load(64'h208, 3'd7, 20'h00056, d, t);
    chk("f3_data", d, mdata(32'h00056208));

    // Line invalidated by reset refills without a write-back
    fill(64'h100, 20'h00034);
    chk("f4_nbeats", log_q.size(), 64'd2);
    b = get_beat(0);
    chk("f4_b0_we",   b.we,   64'h0);
    chk("f4_b0_addr", b.addr, 64'h00034100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
